dp_ram_batch_controller: RTL and testbench
==========================================

Name: dp_ram_batch_controller

Overview:
Parametrised successor to the single-shot DP-RAM mailbox controller. Software (HPS side of the dual-port RAM) writes a job count and up to MAX_JOBS packed operand pairs, then sets CONTROL.start. The block feeds each pair to the external multiplier, writes each result back to RAM, and reports completion, error and job count in STATUS. It sits between the FPGA-side port of the on-chip dual-port RAM and the multiplier core.

Parameters:
DATA_W, 32, RAM word width; must be a multiple of 8 and at least 2*OP_W.
ADDR_W, 8, RAM word-address width; 4+2*MAX_JOBS must not exceed 2**ADDR_W.
OP_W, 4, operand width; A is READ_DATA[OP_W-1:0], B is READ_DATA[2*OP_W-1:OP_W].
MAX_JOBS, 16, maximum operand pairs per batch.
TIMEOUT, 1024, cycles allowed from op_start to op_done before the batch aborts.

Ports:
CLK  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
ADDR  out  ADDR_W  RAM word address.
WRITE_F  out  1  RAM write strobe.
WRITE_DATA  out  DATA_W  RAM write data.
READ_DATA  in  DATA_W  RAM read data; synchronous, valid the cycle after ADDR is presented.
BYTE_ENABLE  out  DATA_W/8  tied all-ones.
A, B  out  OP_W each  registered operands to the multiplier.
op_start  out  1  one-cycle pulse launching a multiply.
op_done  in  1  multiplier result valid; sampled only in WAIT_DONE.
Y  in  2*OP_W  multiplier result.
busy  out  1  high from start detection until STATUS is cleared.
irq  out  1  one-cycle pulse when a batch finishes, if irq_en was latched.
state_o  out  4  current state encoding for debug.

Behaviour:
- Address map (word offsets): CONTROL=0 (bit0 start, bit1 irq_en), STATUS=1, COUNT=2, DATA_IN=4+i, DATA_OUT=4+MAX_JOBS+i.
- STATUS format: bit0 done, bit1 timeout_err, bit2 count_err, bits[15:8] jobs completed.
- Reset: state IDLE, ADDR=0, WRITE_F=0, WRITE_DATA=0, A=B=0, op_start=0, busy=0, irq=0, job index=0, timer=0. No output ever drives X.
- The FSM is Moore. ADDR, WRITE_F and WRITE_DATA are decoded from the state and the job index. Any RAM read needs one presenting cycle before the data can be used.
- IDLE: ADDR=CONTROL. Start is detected when READ_DATA[0]=1 after ADDR has held CONTROL for at least one cycle. On detection, latch irq_en from READ_DATA[1] and go to REQ_COUNT.
- REQ_COUNT: ADDR=COUNT, then go to CHK_COUNT.
- CHK_COUNT: latch cnt=READ_DATA.
  - cnt=0: go to SET_STATUS with done=1 and jobs=0.
  - cnt>MAX_JOBS: go to SET_STATUS with count_err=1, and no RAM writes to DATA_OUT.
  - Otherwise: go to FETCH with index i=0.
- FETCH: ADDR=DATA_IN+i, then go to LOAD.
- LOAD: register A and B from READ_DATA, pulse op_start, clear the timer, then go to WAIT_DONE.
- WAIT_DONE: ADDR=DATA_OUT+i and the timer increments.
  - op_done=1: go to WRITE_RES.
  - Timer reaches TIMEOUT-1 with no op_done: set timeout_err and go to SET_STATUS, leaving the remaining jobs unprocessed.
- WRITE_RES: WRITE_F=1, WRITE_DATA=zero-extended Y, i++. If the new i equals cnt, go to SET_STATUS; otherwise go to FETCH.
- SET_STATUS: WRITE_F=1, ADDR=STATUS, WRITE_DATA={jobs=i, errs, done=1}. Pulse irq if irq_en was latched. Then go to WAIT_RELEASE.
- WAIT_RELEASE: ADDR=CONTROL. The first cycle is ignored because of read latency. Afterwards, go to CLEAR when READ_DATA[0]=0.
- CLEAR: WRITE_F=1, ADDR=STATUS, WRITE_DATA=0, busy drops, then go to IDLE.
- Per-job latency is 4 cycles plus the multiplier time.
- Edge cases:
  - op_done asserted outside WAIT_DONE is ignored.
  - op_done arriving in the same cycle as the timeout has priority (success).
  - rst mid-batch returns to IDLE immediately; RAM contents already written are left as is.
  - Illegal state encodings go to IDLE.

Decomposition:
- Package dp_ram_ctrl_pkg holds:
  - the state enum (IDLE, REQ_COUNT, CHK_COUNT, FETCH, LOAD, WAIT_DONE, WRITE_RES, SET_STATUS, WAIT_RELEASE, CLEAR);
  - the CONTROL, STATUS, COUNT and DATA_IN offsets;
  - the CONTROL and STATUS bit positions.
- One sub-module, op_watchdog, parametrised by TIMEOUT. Inputs are clear and enable; output is expired.

Test Plan:
- Batch of 3, cnt=3, pairs (3,5),(15,15),(0,9), multiplier 2-cycle latency -> DATA_OUT holds 15, 225, 0; STATUS=0x0301; busy high throughout.
- cnt=0 with start=1 -> no op_start pulses; STATUS=0x0001.
- cnt=MAX_JOBS+1 -> STATUS=0x0005 (done plus count_err); no writes to the DATA_OUT range.
- Multiplier never returns op_done on job 2 of 4 -> after TIMEOUT cycles STATUS=0x0103 (done, timeout_err, jobs=1); irq pulses once when irq_en=1.
- Start held high after completion -> stays in WAIT_RELEASE. Drop start -> CLEAR writes STATUS=0, busy=0, back in IDLE.
- rst asserted during WAIT_DONE -> state_o=IDLE, all outputs at their reset values, and a new start runs correctly.

Source files
------------

// File: rtl/dp_ram_batch_controller_pkg.sv
// Shared definitions for the DP-RAM batch controller: FSM states, RAM word
// offsets and register bit positions.
package dp_ram_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        REQ_COUNT    = 4'd1,
        CHK_COUNT    = 4'd2,
        FETCH        = 4'd3,
        LOAD         = 4'd4,
        WAIT_DONE    = 4'd5,
        WRITE_RES    = 4'd6,
        SET_STATUS   = 4'd7,
        WAIT_RELEASE = 4'd8,
        CLEAR        = 4'd9
    } state_t;

    // Word offsets in the shared RAM; DATA_OUT depends on MAX_JOBS and lives in the top
    localparam int CTRL_OFS    = 0;
    localparam int STATUS_OFS  = 1;
    localparam int COUNT_OFS   = 2;
    localparam int DATA_IN_OFS = 4;

    // CONTROL bits
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // STATUS bits
    localparam int STAT_DONE_BIT = 0;
    localparam int STAT_TMO_BIT  = 1;
    localparam int STAT_CNT_BIT  = 2;
    localparam int STAT_JOBS_LSB = 8;

endpackage

// File: rtl/dp_ram_batch_controller_if.sv
// RAM port and multiplier handshake bundle. master = controller side.
interface dp_ram_batch_controller_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int OP_W   = 4
);
    logic [ADDR_W-1:0]   ADDR;
    logic                WRITE_F;
    logic [DATA_W-1:0]   WRITE_DATA;
    logic [DATA_W-1:0]   READ_DATA;
    logic [DATA_W/8-1:0] BYTE_ENABLE;
    logic [OP_W-1:0]     A;
    logic [OP_W-1:0]     B;
    logic                op_start;
    logic                op_done;
    logic [2*OP_W-1:0]   Y;

    modport master (
        output ADDR, WRITE_F, WRITE_DATA, BYTE_ENABLE, A, B, op_start,
        input  READ_DATA, op_done, Y
    );

    modport slave (
        input  ADDR, WRITE_F, WRITE_DATA, BYTE_ENABLE, A, B, op_start,
        output READ_DATA, op_done, Y
    );
endinterface

// File: rtl/dp_ram_batch_controller_op_watchdog.sv
// Multiplier watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count sits at TIMEOUT-1.
module op_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic CLK,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] timer;

    // Cycle counter; saturates at LIMIT so a stuck enable cannot wrap
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            timer <= '0;
        else if (clear)
            timer <= '0;
        else if (enable && timer != LIMIT)
            timer <= timer + CW'(1);
    end

    assign expired = enable && (timer == LIMIT);

endmodule

// File: rtl/dp_ram_batch_controller.sv
// Batch mailbox controller: reads a job count and operand pairs from the
// FPGA port of a dual-port RAM, runs each pair through the external
// multiplier, writes results back and posts STATUS until software releases.
module dp_ram_batch_controller
    import dp_ram_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int OP_W     = 4,
    parameter int MAX_JOBS = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                      CLK,
    input  logic                      rst,
    dp_ram_batch_controller_if.master bus,
    output logic                      busy,
    output logic                      irq,
    output logic [3:0]                state_o
);
    localparam int JW           = $clog2(MAX_JOBS + 1);
    localparam int DATA_OUT_OFS = DATA_IN_OFS + MAX_JOBS;

    state_t          state, state_nxt;
    logic [JW-1:0]   idx, cnt;
    logic [2*OP_W-1:0] res;
    logic            ctl_held;   // ADDR sat on CONTROL last cycle, so READ_DATA is CONTROL
    logic            irq_en, tmo_err, cnt_err, expired;
    logic            cnt_zero, cnt_big;

    assign cnt_zero = (bus.READ_DATA == '0);
    assign cnt_big  = (bus.READ_DATA > DATA_W'(MAX_JOBS));

    op_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .CLK     (CLK),
        .rst     (rst),
        .clear   (state == LOAD),
        .enable  (state == WAIT_DONE),
        .expired (expired)
    );

    // State register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; op_done wins over a same-cycle timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (ctl_held && bus.READ_DATA[CTRL_START_BIT]) state_nxt = REQ_COUNT;
            REQ_COUNT:    state_nxt = CHK_COUNT;
            CHK_COUNT:    state_nxt = (cnt_zero || cnt_big) ? SET_STATUS : FETCH;
            FETCH:        state_nxt = LOAD;
            LOAD:         state_nxt = WAIT_DONE;
            WAIT_DONE:    if (bus.op_done)  state_nxt = WRITE_RES;
                          else if (expired) state_nxt = SET_STATUS;
            WRITE_RES:    state_nxt = ((idx + JW'(1)) == cnt) ? SET_STATUS : FETCH;
            SET_STATUS:   state_nxt = WAIT_RELEASE;
            WAIT_RELEASE: if (ctl_held && !bus.READ_DATA[CTRL_START_BIT]) state_nxt = CLEAR;
            CLEAR:        state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    // Moore RAM-port decode from state and job index
    always_comb begin
        bus.ADDR       = ADDR_W'(CTRL_OFS);
        bus.WRITE_F    = 1'b0;
        bus.WRITE_DATA = '0;
        case (state)
            REQ_COUNT, CHK_COUNT: bus.ADDR = ADDR_W'(COUNT_OFS);
            FETCH, LOAD:          bus.ADDR = ADDR_W'(DATA_IN_OFS) + ADDR_W'(idx);
            WAIT_DONE:            bus.ADDR = ADDR_W'(DATA_OUT_OFS) + ADDR_W'(idx);
            WRITE_RES: begin
                bus.ADDR       = ADDR_W'(DATA_OUT_OFS) + ADDR_W'(idx);
                bus.WRITE_F    = 1'b1;
                bus.WRITE_DATA = DATA_W'(res);
            end
            SET_STATUS: begin
                bus.ADDR                           = ADDR_W'(STATUS_OFS);
                bus.WRITE_F                        = 1'b1;
                bus.WRITE_DATA[STAT_DONE_BIT]      = 1'b1;
                bus.WRITE_DATA[STAT_TMO_BIT]       = tmo_err;
                bus.WRITE_DATA[STAT_CNT_BIT]       = cnt_err;
                bus.WRITE_DATA[STAT_JOBS_LSB +: 8] = 8'(idx);
            end
            CLEAR: begin
                bus.ADDR    = ADDR_W'(STATUS_OFS);
                bus.WRITE_F = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.BYTE_ENABLE = '1;
    assign busy            = (state != IDLE) && (state != CLEAR);
    assign irq             = (state == SET_STATUS) && irq_en;
    assign state_o         = state;

    // Batch datapath: flags, counters, operands and captured result.
    // op_start is registered so it lines up with the freshly loaded A/B.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            ctl_held     <= 1'b0;
            irq_en       <= 1'b0;
            tmo_err      <= 1'b0;
            cnt_err      <= 1'b0;
            idx          <= '0;
            cnt          <= '0;
            res          <= '0;
            bus.A        <= '0;
            bus.B        <= '0;
            bus.op_start <= 1'b0;
        end else begin
            ctl_held     <= (state == IDLE) || (state == WAIT_RELEASE);
            bus.op_start <= (state == LOAD);
            case (state)
                IDLE: if (state_nxt == REQ_COUNT) begin
                    irq_en  <= bus.READ_DATA[CTRL_IRQ_EN_BIT];
                    tmo_err <= 1'b0;
                    cnt_err <= 1'b0;
                    idx     <= '0;
                end
                CHK_COUNT: begin
                    idx     <= '0;
                    cnt_err <= cnt_big;
                    cnt     <= cnt_big ? '0 : bus.READ_DATA[JW-1:0];
                end
                LOAD: begin
                    bus.A <= bus.READ_DATA[OP_W-1:0];
                    bus.B <= bus.READ_DATA[2*OP_W-1:OP_W];
                end
                WAIT_DONE: begin
                    if (bus.op_done)  res     <= bus.Y;
                    else if (expired) tmo_err <= 1'b1;
                end
                WRITE_RES: idx <= idx + JW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_ram_batch_controller.sv
// Directed bench: behavioural dual-port RAM (sync read, software write port)
// and a fixed-latency multiplier around the batch controller.
module tb_dp_ram_batch_controller;
    import dp_ram_ctrl_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int OW   = 4;
    localparam int MJ   = 16;
    localparam int TO   = 32;
    localparam int DOUT = 4 + MJ;
    localparam logic [31:0] SENT = 32'h0000_DEAD;

    logic       CLK = 1'b0;
    logic       rst = 1'b1;
    logic       busy, irq;
    logic [3:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    dp_ram_batch_controller_if #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) bus ();

    dp_ram_batch_controller #(
        .DATA_W(DW), .ADDR_W(AW), .OP_W(OW), .MAX_JOBS(MJ), .TIMEOUT(TO)
    ) dut (
        .CLK     (CLK),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .irq     (irq),
        .state_o (state_o)
    );

    always #5 CLK = ~CLK;

    // RAM: FPGA port from the DUT, software port from the stimulus
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_q;
    logic          sw_we    = 1'b0;
    logic [AW-1:0] sw_addr  = '0;
    logic [DW-1:0] sw_wdata = '0;

    always @(posedge CLK) begin
        rd_q <= mem[bus.ADDR];
        if (bus.WRITE_F) mem[bus.ADDR] <= bus.WRITE_DATA;
        if (sw_we)       mem[sw_addr]  <= sw_wdata;
    end
    assign bus.READ_DATA = rd_q;

    // Multiplier model plus event monitors
    logic        done_q = 1'b0;
    logic [7:0]  y_q    = '0;
    int cd       = 0;
    int mul_lat  = 2;
    int mul_skip = -1;
    int n_start  = 0;
    int n_irq    = 0;
    int n_outwr  = 0;
    int n_busy_bad = 0;

    always @(posedge CLK) begin
        if (rst) begin
            cd     <= 0;
            done_q <= 1'b0;
        end else begin
            done_q <= (cd == 1);
            if (cd > 0) cd <= cd - 1;
            if (bus.op_start) begin
                y_q <= bus.A * bus.B;
                if (n_start != mul_skip) cd <= mul_lat;
            end
        end
        if (bus.op_start) n_start <= n_start + 1;
        if (irq)          n_irq   <= n_irq + 1;
        if (bus.WRITE_F && bus.ADDR >= DOUT && bus.ADDR < DOUT + MJ) n_outwr <= n_outwr + 1;
        if (!rst && state_o != 4'd0 && state_o != 4'd9 && !busy) n_busy_bad <= n_busy_bad + 1;
    end
    assign bus.op_done = done_q;
    assign bus.Y       = y_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sw_wr(input int a, input logic [31:0] d);
        sw_addr  = AW'(a);
        sw_wdata = d;
        sw_we    = 1'b1;
        @(posedge CLK); #1;
        sw_we    = 1'b0;
    endtask

    task automatic wait_st(input logic [3:0] s, input int lim, input string tag);
        int k = 0;
        while (state_o !== s && k < lim) begin
            @(posedge CLK); #1;
            k++;
        end
        chk(tag, 32'(state_o), 32'(s));
    endtask

    task automatic release_ctl(input string tag);
        sw_wr(0, 0);
        wait_st(IDLE, 20, {tag, "_idle"});
        chk({tag, "_stat0"}, mem[1], 32'h0);
        chk({tag, "_busy0"}, 32'(busy), 32'h0);
    endtask

    int s0, i0, o0;

    initial begin
        // reset values, RAM mailbox initialised under reset
        sw_wr(0, 0);
        sw_wr(1, 0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_addr",  32'(bus.ADDR), 32'd0);
        chk("rst_wf",    32'(bus.WRITE_F), 32'd0);
        chk("rst_wd",    bus.WRITE_DATA, 32'd0);
        chk("rst_a",     32'(bus.A), 32'd0);
        chk("rst_b",     32'(bus.B), 32'd0);
        chk("rst_start", 32'(bus.op_start), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_irq",   32'(irq), 32'd0);
        chk("be",        32'(bus.BYTE_ENABLE), 32'hF);
        rst = 1'b0;
        @(posedge CLK); #1;

        // batch of 3, irq enabled
        sw_wr(2, 3);
        sw_wr(4, 32'h53); sw_wr(5, 32'hFF); sw_wr(6, 32'h90);
        for (int i = 0; i < 3; i++) sw_wr(DOUT + i, SENT);
        s0 = n_start; i0 = n_irq;
        sw_wr(0, 3);
        wait_st(WAIT_RELEASE, 200, "b3_reach");
        repeat (10) @(posedge CLK);
        #1;
        chk("b3_hold",   32'(state_o), 32'd8);
        chk("b3_r0",     mem[DOUT],     32'd15);
        chk("b3_r1",     mem[DOUT + 1], 32'd225);
        chk("b3_r2",     mem[DOUT + 2], 32'd0);
        chk("b3_status", mem[1], 32'h0301);
        chk("b3_starts", 32'(n_start - s0), 32'd3);
        chk("b3_irq",    32'(n_irq - i0), 32'd1);
        chk("b3_busy",   32'(busy), 32'd1);
        chk("b3_busyok", 32'(n_busy_bad), 32'd0);
        release_ctl("b3_rel");

        // zero count, irq disabled
        sw_wr(2, 0);
        s0 = n_start; i0 = n_irq;
        sw_wr(0, 1);
        wait_st(WAIT_RELEASE, 100, "c0_reach");
        chk("c0_status", mem[1], 32'h0001);
        chk("c0_starts", 32'(n_start - s0), 32'd0);
        chk("c0_irq",    32'(n_irq - i0), 32'd0);
        release_ctl("c0_rel");

        // count one above MAX_JOBS
        sw_wr(2, MJ + 1);
        s0 = n_start; o0 = n_outwr;
        sw_wr(0, 1);
        wait_st(WAIT_RELEASE, 100, "cb_reach");
        chk("cb_status", mem[1], 32'h0005);
        chk("cb_outwr",  32'(n_outwr - o0), 32'd0);
        chk("cb_starts", 32'(n_start - s0), 32'd0);
        release_ctl("cb_rel");

        // batch of 4, multiplier never answers job 2
        sw_wr(2, 4);
        sw_wr(4, 32'h32); sw_wr(5, 32'h44); sw_wr(6, 32'h11); sw_wr(7, 32'h55);
        for (int i = 0; i < 4; i++) sw_wr(DOUT + i, SENT);
        s0 = n_start; i0 = n_irq;
        mul_skip = n_start + 1;
        sw_wr(0, 3);
        wait_st(WAIT_RELEASE, 400, "to_reach");
        chk("to_status", mem[1], 32'h0103);
        chk("to_r0",     mem[DOUT],     32'd6);
        chk("to_r1",     mem[DOUT + 1], SENT);
        chk("to_r2",     mem[DOUT + 2], SENT);
        chk("to_irq",    32'(n_irq - i0), 32'd1);
        chk("to_starts", 32'(n_start - s0), 32'd2);
        mul_skip = -1;
        release_ctl("to_rel");

        // reset during WAIT_DONE, then the still-set start reruns the batch
        sw_wr(2, 2);
        sw_wr(4, 32'h67); sw_wr(5, 32'h82);
        sw_wr(DOUT, SENT); sw_wr(DOUT + 1, SENT);
        mul_lat = 20;
        sw_wr(0, 1);
        wait_st(WAIT_DONE, 50, "rs_wd");
        repeat (3) @(posedge CLK);
        #1;
        rst = 1'b1;
        #1;
        chk("rs_state", 32'(state_o), 32'd0);
        chk("rs_addr",  32'(bus.ADDR), 32'd0);
        chk("rs_wf",    32'(bus.WRITE_F), 32'd0);
        chk("rs_a",     32'(bus.A), 32'd0);
        chk("rs_b",     32'(bus.B), 32'd0);
        chk("rs_start", 32'(bus.op_start), 32'd0);
        chk("rs_busy",  32'(busy), 32'd0);
        chk("rs_r0",    mem[DOUT], SENT);
        mul_lat = 2;
        @(posedge CLK); #1;
        rst = 1'b0;
        wait_st(WAIT_RELEASE, 200, "rs_reach");
        chk("rs_r0b",    mem[DOUT],     32'd42);
        chk("rs_r1b",    mem[DOUT + 1], 32'd16);
        chk("rs_status", mem[1], 32'h0201);
        release_ctl("rs_rel");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
